// File: rtl/pixel_deframer_pkg.sv
// Shared definitions for the packed video pixel word and the decoded pixel beat.
package pixel_deframer_pkg;

    localparam int unsigned RGB_MSB = 25;
    localparam int unsigned RGB_LSB = 2;
    localparam int unsigned SOP_BIT = 1;
    localparam int unsigned EOP_BIT = 0;

    // Coordinates are carried at a fixed width; the top trims them to the geometry.
    localparam int unsigned COORD_W = 16;

    typedef enum logic [1:0] {
        ErrNoSop      = 2'd0,
        ErrEarlySop   = 2'd1,
        ErrShortFrame = 2'd2,
        ErrLongFrame  = 2'd3
    } err_code_t;

    typedef struct packed {
        logic [23:0]        rgb;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               eol;
        logic               eof;
    } pix_beat_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer with a registered ready; the head entry drives the output.
module skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             in_ready_q;
    logic             push;
    logic             pop;

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = in_valid && in_ready_q;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q    <= count_d;
            // Ready next cycle only if an entry is still free after this edge.
            in_ready_q <= (count_d != 2'd2);
        end
    end

endmodule

// File: rtl/pixel_deframer.sv
// Validates sop/eop framing against the geometry and emits RGB with x/y and eol/eof markers.
module pixel_deframer
    import pixel_deframer_pkg::*;
#(
    parameter int unsigned LINE_WIDTH   = 640,
    parameter int unsigned FRAME_HEIGHT = 480,
    parameter int unsigned DATA_WIDTH   = 26
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [23:0]                     out_rgb,
    output logic [$clog2(LINE_WIDTH)-1:0]   out_x,
    output logic [$clog2(FRAME_HEIGHT)-1:0] out_y,
    output logic                            out_eol,
    output logic                            out_eof,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            err_valid,
    output logic [1:0]                      err_code,
    output logic [15:0]                     frame_count
);

    localparam int unsigned XW = $clog2(LINE_WIDTH);
    localparam int unsigned YW = $clog2(FRAME_HEIGHT);

    typedef enum logic {StIdle, StActive} state_e;

    state_e    state_q, state_d;
    logic [XW-1:0] x_q, x_d, px;
    logic [YW-1:0] y_q, y_d, py;
    logic      nosop_q, nosop_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic      err_valid_q, err_valid_d;
    err_code_t err_code_q, err_code_d;

    logic      sop, eop, accept, early, last_x, last_y, push;
    pix_beat_t beat_in, beat_out;

    assign sop    = in_data[SOP_BIT];
    assign eop    = in_data[EOP_BIT];
    assign accept = in_valid && in_ready;
    assign early  = (state_q == StActive) && sop;
    // A sop word always starts at the origin, whatever the counters hold.
    assign px     = sop ? '0 : x_q;
    assign py     = sop ? '0 : y_q;
    assign last_x = (px == XW'(LINE_WIDTH - 1));
    assign last_y = (py == YW'(FRAME_HEIGHT - 1));

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        nosop_d       = nosop_q;
        frame_count_d = frame_count_q;
        err_valid_d   = 1'b0;
        err_code_d    = ErrNoSop;
        push          = 1'b0;
        beat_in.rgb   = in_data[RGB_MSB:RGB_LSB];
        beat_in.x     = COORD_W'(px);
        beat_in.y     = COORD_W'(py);
        beat_in.eol   = last_x;
        beat_in.eof   = 1'b0;
        if (accept) begin
            if (state_q == StIdle && !sop) begin
                err_valid_d = !nosop_q;
                nosop_d     = 1'b1;
            end else begin
                push = 1'b1;
                if (eop || (last_x && last_y)) begin
                    beat_in.eof = 1'b1;
                    state_d     = StIdle;
                    nosop_d     = 1'b0;
                    x_d         = '0;
                    y_d         = '0;
                    if (eop && last_x && last_y && !early) begin
                        frame_count_d = frame_count_q + 16'd1;
                    end
                end else begin
                    state_d = StActive;
                    if (last_x) begin
                        x_d = '0;
                        y_d = py + 1'b1;
                    end else begin
                        x_d = px + 1'b1;
                        y_d = py;
                    end
                end
                if (early) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ErrEarlySop;
                end else if (eop && !(last_x && last_y)) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ErrShortFrame;
                end else if (!eop && last_x && last_y) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ErrLongFrame;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            x_q           <= '0;
            y_q           <= '0;
            nosop_q       <= 1'b0;
            frame_count_q <= '0;
            err_valid_q   <= 1'b0;
            err_code_q    <= ErrNoSop;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            nosop_q       <= nosop_d;
            frame_count_q <= frame_count_d;
            err_valid_q   <= err_valid_d;
            err_code_q    <= err_code_d;
        end
    end

    skid_buffer #(
        .WIDTH($bits(pix_beat_t))
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  (beat_in),
        .in_valid (push),
        .in_ready (in_ready),
        .out_data (beat_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    assign out_rgb     = beat_out.rgb;
    assign out_x       = beat_out.x[XW-1:0];
    assign out_y       = beat_out.y[YW-1:0];
    assign out_eol     = beat_out.eol;
    assign out_eof     = beat_out.eof;
    assign err_valid   = err_valid_q;
    assign err_code    = err_code_q;
    assign frame_count = frame_count_q;

    logic unused_coord_bits;
    assign unused_coord_bits = ^{beat_out.x[COORD_W-1:XW], beat_out.y[COORD_W-1:YW]};

endmodule

// File: tb/tb_pixel_deframer.sv
// Scoreboard bench for pixel_deframer on a 4x3 geometry.
module tb_pixel_deframer;

    localparam int LW = 4;
    localparam int FH = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [25:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] out_rgb;
    logic [1:0]  out_x;
    logic [1:0]  out_y;
    logic        out_eol, out_eof, out_valid;
    logic        out_ready = 1'b1;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    pixel_deframer #(
        .LINE_WIDTH  (LW),
        .FRAME_HEIGHT(FH),
        .DATA_WIDTH  (26)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_rgb    (out_rgb),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .frame_count(frame_count)
    );

    typedef struct packed {
        logic [23:0] rgb;
        logic [1:0]  x;
        logic [1:0]  y;
        logic        eol;
        logic        eof;
    } exp_beat_t;

    exp_beat_t  exp_q[$];
    logic [1:0] err_log[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         exp_frames = 0;
    int         ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    exp_beat_t got, held, want;
    logic      stalled_prev = 1'b0;
    int        stall_run = 0;

    always @(negedge clk) begin
        if (rst) begin
            stalled_prev = 1'b0;
            stall_run    = 0;
        end else begin
            got = {out_rgb, out_x, out_y, out_eol, out_eof};
            if (stalled_prev) begin
                n_checks++;
                if (out_valid !== 1'b1 || got !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%b beat=%h, required valid=1 beat=%h",
                             out_valid, got, held);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h, required no beat", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL beat: got rgb=%h x=%0d y=%0d eol=%b eof=%b, required rgb=%h x=%0d y=%0d eol=%b eof=%b",
                                 got.rgb, got.x, got.y, got.eol, got.eof,
                                 want.rgb, want.x, want.y, want.eol, want.eof);
                    end
                end
            end
            stalled_prev = out_valid && !out_ready;
            held         = got;
            if (out_valid && !out_ready && in_valid) stall_run++;
            else stall_run = 0;
            if (stall_run >= 3) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ready_drop: in_ready=%b after %0d stalled cycles, required 0",
                             in_ready, stall_run);
                end
            end
            if (err_valid) err_log.push_back(err_code);
        end
    end

    task automatic send(input logic [23:0] rgb, input logic sop, input logic eop,
                        output int cycles);
        logic rdy;
        in_data  = {rgb, sop, eop};
        in_valid = 1'b1;
        cycles   = 0;
        rdy      = 1'b0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            cycles++;
        end while (!rdy && cycles < 200);
        in_valid = 1'b0;
        if (!rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=0 for %0d cycles, required 1", cycles);
        end
    endtask

    task automatic drain(output bit ok);
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        ok = (exp_q.size() == 0);
        exp_q.delete();
    endtask

    task automatic push_exp(input logic [23:0] rgb, input int pos, input logic eof);
        exp_q.push_back('{rgb: rgb, x: 2'(pos % LW), y: 2'(pos / LW),
                          eol: (pos % LW) == LW - 1, eof: eof});
    endtask

    task automatic send_clean_frame(output int total);
        logic [23:0] rgb;
        int c;
        total = 0;
        for (int i = 0; i < LW * FH; i++) begin
            rgb = 24'($urandom());
            push_exp(rgb, i, i == LW * FH - 1);
            send(rgb, i == 0, i == LW * FH - 1, c);
            total += c;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, out_eol, out_eof, err_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 00000",
                     {in_ready, out_valid, out_eol, out_eof, err_valid});
        end
        n_checks++;
        if ({out_rgb, out_x, out_y, err_code, frame_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: rgb=%h x=%0d y=%0d code=%0d frames=%0d, required all 0",
                     out_rgb, out_x, out_y, err_code, frame_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_reset_early: got %b, required 0", in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame_and_errs(input string name, input int n_err,
                                        input logic [1:0] e0, input logic [1:0] e1);
        n_checks++;
        if (frame_count !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL %s_frame_count: got %0d, required %0d", name, frame_count, exp_frames);
        end
        n_checks++;
        if (err_log.size() != n_err) begin
            n_fail++;
            $display("FAIL %s_err_count: got %0d pulses, required %0d", name, err_log.size(), n_err);
        end else begin
            if (n_err > 0) begin
                n_checks++;
                if (err_log[0] !== e0) begin
                    n_fail++;
                    $display("FAIL %s_err_code0: got %0d, required %0d", name, err_log[0], e0);
                end
            end
            if (n_err > 1) begin
                n_checks++;
                if (err_log[1] !== e1) begin
                    n_fail++;
                    $display("FAIL %s_err_code1: got %0d, required %0d", name, err_log[1], e1);
                end
            end
        end
        err_log.delete();
    endtask

    task automatic check_drained(input string name, input bit ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_drain: expected beats still pending, required none", name);
        end
    endtask

    task automatic test_clean_frame;
        int total;
        bit ok;
        err_log.delete();
        send_clean_frame(total);
        n_checks++;
        if (total != LW * FH) begin
            n_fail++;
            $display("FAIL throughput: got %0d cycles for %0d words, required %0d",
                     total, LW * FH, LW * FH);
        end
        drain(ok);
        check_drained("clean", ok);
        exp_frames++;
        check_frame_and_errs("clean", 0, 2'd0, 2'd0);
    endtask

    task automatic test_backpressure;
        int total;
        bit ok;
        err_log.delete();
        ready_mode = 2;
        send_clean_frame(total);
        drain(ok);
        ready_mode = 1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_drained("backpressure", ok);
        exp_frames++;
        check_frame_and_errs("backpressure", 0, 2'd0, 2'd0);
    endtask

    task automatic test_garbage_before_sop;
        int total, c;
        bit ok;
        err_log.delete();
        for (int i = 0; i < 3; i++) send(24'($urandom()), 1'b0, 1'b0, c);
        send_clean_frame(total);
        drain(ok);
        check_drained("garbage", ok);
        exp_frames++;
        check_frame_and_errs("garbage", 1, 2'd0, 2'd0);
    endtask

    task automatic test_early_sop;
        logic [23:0] rgb;
        int c, j;
        bit ok;
        err_log.delete();
        for (int k = 0; k < 17; k++) begin
            rgb = 24'($urandom());
            j = (k < 5) ? k : k - 5;
            push_exp(rgb, j, k == 16);
            send(rgb, j == 0, k == 16, c);
        end
        drain(ok);
        check_drained("early_sop", ok);
        exp_frames++;
        check_frame_and_errs("early_sop", 1, 2'd1, 2'd0);
    endtask

    task automatic test_short_frame;
        logic [23:0] rgb;
        int c;
        bit ok;
        err_log.delete();
        for (int i = 0; i < 8; i++) begin
            rgb = 24'($urandom());
            push_exp(rgb, i, i == 7);
            send(rgb, i == 0, i == 7, c);
        end
        send(24'($urandom()), 1'b0, 1'b0, c);  // dropped in idle
        drain(ok);
        check_drained("short", ok);
        check_frame_and_errs("short", 2, 2'd2, 2'd0);
    endtask

    task automatic test_long_frame;
        logic [23:0] rgb;
        int c;
        bit ok;
        err_log.delete();
        for (int i = 0; i < 14; i++) begin
            rgb = 24'($urandom());
            if (i < LW * FH) push_exp(rgb, i, i == LW * FH - 1);
            send(rgb, i == 0, 1'b0, c);
        end
        drain(ok);
        check_drained("long", ok);
        check_frame_and_errs("long", 2, 2'd3, 2'd0);
    endtask

    task automatic test_reset_mid_frame;
        logic [23:0] rgb;
        int c, total;
        bit ok;
        err_log.delete();
        for (int i = 0; i < 5; i++) begin
            rgb = 24'($urandom());
            push_exp(rgb, i, 1'b0);
            send(rgb, i == 0, 1'b0, c);
        end
        drain(ok);
        check_drained("mid_reset_pre", ok);
        ready_mode = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        send(24'($urandom()), 1'b0, 1'b0, c);
        send(24'($urandom()), 1'b0, 1'b0, c);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, out_eol, out_eof, err_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_reset_flags: got %b, required 00000",
                     {in_ready, out_valid, out_eol, out_eof, err_valid});
        end
        n_checks++;
        if ({out_rgb, out_x, out_y, err_code, frame_count} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_data: rgb=%h x=%0d y=%0d code=%0d frames=%0d, required all 0",
                     out_rgb, out_x, out_y, err_code, frame_count);
        end
        ready_mode = 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_frames = 0;
        err_log.delete();
        send_clean_frame(total);
        drain(ok);
        check_drained("mid_reset_post", ok);
        exp_frames++;
        check_frame_and_errs("mid_reset", 0, 2'd0, 2'd0);
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_backpressure();
        test_garbage_before_sop();
        test_early_sop();
        test_short_frame();
        test_long_frame();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

// File: doc/pixel_deframer.md
# pixel_deframer

Receive-side decoder for the packed video pixel word used by the filter pipeline (`{red, green, blue, sop, eop}`). It consumes a valid/ready stream of packed words, validates frame framing against the configured geometry, strips the sop/eop flags, and emits RGB with explicit x/y coordinates and end-of-line/end-of-frame markers. It sits at the tail of the filter chain, downstream of the line buffers, and feeds consumers that need coordinates rather than in-band flags.

## Interface
- `LINE_WIDTH`, default 640: pixels per line.
- `FRAME_HEIGHT`, default 480: lines per frame.
- `DATA_WIDTH`, default 26: packed word width. Fixed layout:
  - [25:18] red, [17:10] green, [9:2] blue.
  - [1] sop, [0] eop.
- `clk` input 1: clock; all logic is on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_data` input DATA_WIDTH: packed pixel word.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block can accept a word. Registered.
- `out_rgb` output 24: `{r, g, b}`.
- `out_x` output $clog2(LINE_WIDTH): pixel column.
- `out_y` output $clog2(FRAME_HEIGHT): pixel row.
- `out_eol` output 1: last pixel of a line.
- `out_eof` output 1: last pixel of a frame, normal or truncated.
- `out_valid` output 1: output beat valid.
- `out_ready` input 1: downstream accepts the output beat.
- `err_valid` output 1: one-cycle error pulse.
- `err_code` output 2:
  - 0: NO_SOP.
  - 1: EARLY_SOP.
  - 2: SHORT_FRAME.
  - 3: LONG_FRAME.
- `frame_count` output 16: count of frames that completed cleanly. Wraps at 2^16.

## Operation
- An input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- FSM states are IDLE and ACTIVE. Reset enters IDLE with x=0 and y=0.
- IDLE:
  - A word with sop=1 is forwarded as pixel (0,0). The FSM moves to ACTIVE.
  - A word with sop=0 is accepted and dropped. The first such drop after entering IDLE raises NO_SOP; later drops in the same idle run raise nothing.
  - A word with sop=1 and eop=1 is forwarded with eof=1. It raises SHORT_FRAME and the FSM stays in IDLE, unless the geometry is 1x1, which counts as a clean frame.
- ACTIVE, for each accepted word:
  - sop=1: the frame restarts. The word is forwarded as (0,0) and EARLY_SOP is raised.
  - eop=1 at (LINE_WIDTH-1, FRAME_HEIGHT-1): eol=eof=1 and `frame_count` increments. The FSM goes to IDLE.
  - eop=1 anywhere else: forwarded with eof=1 (eol set only if x=LINE_WIDTH-1). SHORT_FRAME is raised and the FSM goes to IDLE.
  - eop=0 at the last position: forwarded with eol=eof=1. LONG_FRAME is raised and the FSM goes to IDLE. The following words are then dropped under the IDLE rules.
  - Otherwise, x increments. At x=LINE_WIDTH-1, eol=1, x wraps to 0 and y increments.
- Error priority within one word: EARLY_SOP > SHORT_FRAME > LONG_FRAME. At most one `err_valid` is raised per accepted word.
- Backpressure never drops a forwarded pixel. Dropped words never reach the output.

## Timing
- Latency is 1 cycle: a word accepted at edge N is presented on the output after edge N when the output is empty.
- The output stage is a 2-entry skid buffer.
  - `in_ready` is registered: it is 1 when at least one skid entry will be free next cycle.
  - Sustained throughput is 1 word/cycle while `out_ready` is held at 1.
- `out_*` are held stable while `out_valid && !out_ready`.
- `err_valid` pulses in the cycle after the offending word is accepted. It does not depend on `out_ready`.
- Reset values:
  - `in_ready`, `out_valid`, `out_eol`, `out_eof`, `err_valid`: 0.
  - `out_rgb`, `out_x`, `out_y`, `err_code`, `frame_count`: 0.
  - `in_ready` rises 1 cycle after `rst` deasserts.
- Reset mid-frame empties the skid buffer, discards any pending beats and clears the counters. After reset the block waits for sop.

## Structure
- The shared video package holds:
  - Bit-position constants for the packed word (RGB_MSB, SOP_BIT, EOP_BIT).
  - An `err_code_t` enum.
  - A `pix_beat_t` struct: rgb, x, y, eol, eof.
- Sub-module `skid_buffer`, parameterised on payload width, carries `pix_beat_t` and holds the handshake logic. The FSM and counters stay in `pixel_deframer`.

## Test plan
All scenarios use LINE_WIDTH=4 and FRAME_HEIGHT=3.
- Clean frame: 12 words with sop on word 0, eop on word 11, `out_ready`=1.
  - 12 beats out with (x,y) from (0,0) to (3,2).
  - eol on x=3; eof only on the last beat.
  - `frame_count`=1 and no errors.
- Backpressure: the clean frame with `out_ready` toggled randomly, 50%.
  - Identical beat sequence, with no loss or duplication.
  - `out_*` stable while stalled.
  - `in_ready` drops within 2 cycles of a stall.
- Garbage before sop: 3 words with sop=0, then a clean frame.
  - Exactly one NO_SOP pulse.
  - The 3 words are not output; then 12 beats out.
- Early sop: sop again at word 5.
  - EARLY_SOP is raised and word 5 is output as (0,0).
  - The next 11 words complete the frame cleanly.
- Short and long frames:
  - eop on word 7: (3,1) is output with eol=eof=1, SHORT_FRAME is raised, and the FSM is in IDLE.
  - 14 words with no eop: word 11 is output with eof=1 and LONG_FRAME; words 12 and 13 are dropped with one NO_SOP.
- Reset mid-frame: assert `rst` after word 6 while `out_ready`=0.
  - All outputs go to 0 and no stale beats appear afterward.
  - A following clean frame decodes from (0,0).
